// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer
// Purpose  : Runs one recognition pass. It resets and arms the classifier,
//            starts the FFT, streams NUM_SAMPLES samples into the FFT, waits
//            for the alpha/zulu decision, reports it, then holds off before
//            it can re-arm.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
  parameter int          NUM_SAMPLES = 8192,
  parameter int          CNT_W       = 14,
  parameter int          SAMPLE_W    = 16,
  parameter logic [31:0] TIMEOUT     = 32'd1000000,
  parameter logic [23:0] HOLDOFF     = 24'd5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_arm,
  input  logic                i_auto_rearm,
  input  logic                i_smp_valid,
  input  logic [SAMPLE_W-1:0] i_smp_in,
  input  logic                i_fft_rfd,
  output logic                o_fft_start,
  output logic [SAMPLE_W-1:0] o_fft_xn_re,
  output logic                o_fft_we,
  output logic                o_clf_rst,
  output logic                o_clf_start,
  input  logic                i_clf_alpha,
  input  logic                i_clf_zulu,
  output logic                o_result_valid,
  output logic                o_result_alpha,
  output logic                o_result_zulu,
  output logic                o_busy,
  output logic                o_err_overrun,
  output logic                o_err_timeout
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CLR    = 3'd1;
  localparam logic [2:0] c_ARM    = 3'd2;
  localparam logic [2:0] c_START  = 3'd3;
  localparam logic [2:0] c_LOAD   = 3'd4;
  localparam logic [2:0] c_WAIT   = 3'd5;
  localparam logic [2:0] c_REPORT = 3'd6;
  localparam logic [2:0] c_HOLD   = 3'd7;

  localparam logic [CNT_W-1:0] c_LAST_SMP  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [31:0]      c_TO_LAST   = TIMEOUT - 32'd1;
  localparam logic [23:0]      c_HOLD_LAST = HOLDOFF - 24'd1;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [31:0]      r_to_cnt;
  logic [23:0]      r_hold_cnt;
  logic             r_res_alpha;
  logic             r_res_zulu;
  logic             r_err_overrun;
  logic             r_err_timeout;

  logic w_load;
  logic w_accept;
  logic w_drop;
  logic w_decided;

  assign w_load    = (r_state == c_LOAD);
  assign w_accept  = w_load & i_smp_valid & i_fft_rfd;
  assign w_drop    = w_load & i_smp_valid & ~i_fft_rfd;
  assign w_decided = i_clf_alpha | i_clf_zulu;

  // Pass sequencing: state, sample/timeout/holdoff counters, results, errors.
  // The holdoff counter starts on the REPORT cycle, so the next CLR lands
  // exactly HOLDOFF cycles after the result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_smp_cnt     <= '0;
      r_to_cnt      <= '0;
      r_hold_cnt    <= '0;
      r_res_alpha   <= 1'b0;
      r_res_zulu    <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_arm) r_state <= c_CLR;
        end
        c_CLR: begin
          r_smp_cnt     <= '0;
          r_res_alpha   <= 1'b0;
          r_res_zulu    <= 1'b0;
          r_err_overrun <= 1'b0;
          r_err_timeout <= 1'b0;
          r_state       <= c_ARM;
        end
        c_ARM:   r_state <= c_START;
        c_START: r_state <= c_LOAD;
        c_LOAD: begin
          if (w_accept) begin
            if (r_smp_cnt == c_LAST_SMP) begin
              r_smp_cnt <= '0;
              r_to_cnt  <= '0;
              r_state   <= c_WAIT;
            end else begin
              r_smp_cnt <= r_smp_cnt + 1'b1;
            end
          end else if (w_drop) begin
            r_err_overrun <= 1'b1;
          end
        end
        c_WAIT: begin
          // A decision arriving on the final timeout cycle takes priority.
          if (w_decided) begin
            r_res_alpha <= i_clf_alpha;
            r_res_zulu  <= i_clf_zulu;
            r_hold_cnt  <= '0;
            r_state     <= c_REPORT;
          end else if (r_to_cnt == c_TO_LAST) begin
            r_res_alpha   <= 1'b0;
            r_res_zulu    <= 1'b0;
            r_err_timeout <= 1'b1;
            r_hold_cnt    <= '0;
            r_state       <= c_REPORT;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        c_REPORT: begin
          r_hold_cnt <= r_hold_cnt + 24'd1;
          r_state    <= c_HOLD;
        end
        c_HOLD: begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            r_state <= (i_auto_rearm | i_arm) ? c_CLR : c_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 24'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Control pulses decode straight from the registered state; only the
  // sample pass-through and its write enable depend on live inputs.
  assign o_clf_rst      = (r_state == c_CLR);
  assign o_clf_start    = (r_state == c_ARM);
  assign o_fft_start    = (r_state == c_START);
  assign o_result_valid = (r_state == c_REPORT);
  assign o_busy         = (r_state != c_IDLE);
  assign o_fft_we       = w_accept;
  assign o_fft_xn_re    = w_accept ? i_smp_in : '0;
  assign o_result_alpha = r_res_alpha;
  assign o_result_zulu  = r_res_zulu;
  assign o_err_overrun  = r_err_overrun;
  assign o_err_timeout  = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_sequencer
// Purpose  : Self-checking bench for fft_frame_sequencer. A timestamp model
//            predicts every output each cycle; directed passes add literal
//            checks on pulse counts and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;

  localparam int          NS = 16;
  localparam int          TO = 50;
  localparam int          HO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        auto_rearm = 1'b0;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_in = '0;
  logic        fft_rfd = 1'b1;
  logic        clf_alpha = 1'b0;
  logic        clf_zulu = 1'b0;
  logic        fft_start, fft_we, clf_rst, clf_start;
  logic [15:0] fft_xn_re;
  logic        result_valid, result_alpha, result_zulu, busy;
  logic        err_overrun, err_timeout;

  int n_pass = 0;
  int n_tot  = 0;

  fft_frame_sequencer #(
    .NUM_SAMPLES(NS), .CNT_W(5), .SAMPLE_W(16),
    .TIMEOUT(32'd50), .HOLDOFF(24'd20)
  ) dut (
    .clk(clk), .rst(rst), .i_arm(arm), .i_auto_rearm(auto_rearm),
    .i_smp_valid(smp_valid), .i_smp_in(smp_in), .i_fft_rfd(fft_rfd),
    .o_fft_start(fft_start), .o_fft_xn_re(fft_xn_re), .o_fft_we(fft_we),
    .o_clf_rst(clf_rst), .o_clf_start(clf_start),
    .i_clf_alpha(clf_alpha), .i_clf_zulu(clf_zulu),
    .o_result_valid(result_valid), .o_result_alpha(result_alpha),
    .o_result_zulu(result_zulu), .o_busy(busy),
    .o_err_overrun(err_overrun), .o_err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic timed_out(input string name);
    n_tot++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- model: pass timeline as cycle timestamps ----------------
  int cyc = 0;
  int m_go = -1;    // cycle of the expected clf_rst pulse
  int m_last = -1;  // cycle of the final accepted sample
  int m_rep = -1;   // cycle of the expected result strobe
  int m_cnt = 0;
  bit m_busy = 0, m_ra = 0, m_rz = 0, m_eo = 0, m_eto = 0;

  // monitor stamps
  int n_clr, n_cs, n_fs, n_we, n_rv;
  int t_clr, t_cs, t_fs, t_we_first, t_we_last, t_rv, t_idle;
  bit rv_a, rv_z, prev_busy = 0;

  task automatic clr_mon();
    n_clr = 0; n_cs = 0; n_fs = 0; n_we = 0; n_rv = 0;
    t_clr = -1; t_cs = -1; t_fs = -1; t_we_first = -1; t_we_last = -1;
    t_rv = -1; t_idle = -1;
  endtask

  // Compare every output against the model, record events, then advance.
  always @(negedge clk) begin
    bit e_load, e_we, e_wait;
    e_load = (m_go >= 0) && (cyc >= m_go + 3) && (m_last < 0);
    e_we   = e_load && smp_valid && fft_rfd;
    e_wait = (m_last >= 0) && (m_rep < 0) && (cyc > m_last);

    chk("busy",         busy,         m_busy);
    chk("clf_rst",      clf_rst,      (m_go >= 0) && (cyc == m_go));
    chk("clf_start",    clf_start,    (m_go >= 0) && (cyc == m_go + 1));
    chk("fft_start",    fft_start,    (m_go >= 0) && (cyc == m_go + 2));
    chk("fft_we",       fft_we,       e_we);
    chk("fft_xn_re",    fft_xn_re,    e_we ? smp_in : 16'd0);
    chk("result_valid", result_valid, (m_rep >= 0) && (cyc == m_rep));
    chk("result_alpha", result_alpha, m_ra);
    chk("result_zulu",  result_zulu,  m_rz);
    chk("err_overrun",  err_overrun,  m_eo);
    chk("err_timeout",  err_timeout,  m_eto);

    if (clf_rst)   begin n_clr++; t_clr = cyc; end
    if (clf_start) begin n_cs++;  t_cs  = cyc; end
    if (fft_start) begin n_fs++;  t_fs  = cyc; end
    if (fft_we) begin
      if (n_we == 0) t_we_first = cyc;
      n_we++; t_we_last = cyc;
    end
    if (result_valid) begin n_rv++; t_rv = cyc; rv_a = result_alpha; rv_z = result_zulu; end
    if (prev_busy && !busy) t_idle = cyc;
    prev_busy = busy;

    if (rst) begin
      m_go = -1; m_last = -1; m_rep = -1; m_cnt = 0;
      m_busy = 0; m_ra = 0; m_rz = 0; m_eo = 0; m_eto = 0;
    end else begin
      if ((m_go >= 0) && (cyc == m_go)) begin m_eo = 0; m_eto = 0; m_ra = 0; m_rz = 0; end
      if (e_load && smp_valid && !fft_rfd) m_eo = 1;
      if (e_we) begin
        m_cnt++;
        if (m_cnt == NS) m_last = cyc;
      end
      if (e_wait) begin
        if (clf_alpha || clf_zulu) begin
          m_rep = cyc + 1; m_ra = clf_alpha; m_rz = clf_zulu;
        end else if (cyc == m_last + TO) begin
          m_rep = cyc + 1; m_ra = 0; m_rz = 0; m_eto = 1;
        end
      end
      if (!m_busy) begin
        if (arm) begin
          m_busy = 1; m_go = cyc + 1; m_cnt = 0; m_last = -1; m_rep = -1;
        end
      end else if ((m_rep >= 0) && (cyc == m_rep + HO - 1)) begin
        if (arm || auto_rearm) begin
          m_go = cyc + 1; m_cnt = 0; m_last = -1; m_rep = -1;
        end else begin
          m_busy = 0; m_go = -1;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_pass();
    arm = 1; tick(); arm = 0;
    repeat (3) tick();
  endtask

  // One strobe every 4 cycles; strobes drop_from..drop_from+drop_n-1 see fft_rfd=0.
  task automatic feed(input int n, input int drop_from, input int drop_n);
    for (int k = 0; k < n + drop_n; k++) begin
      if (k > 0) repeat (3) tick();
      smp_valid = 1; smp_in = 16'($urandom);
      fft_rfd = !((k >= drop_from) && (k < drop_from + drop_n));
      tick();
      smp_valid = 0; fft_rfd = 1;
    end
  endtask

  task automatic pulse_alpha_after(input int gap);
    repeat (gap - 1) tick();
    clf_alpha = 1; tick(); clf_alpha = 0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 400 && busy; i++) tick();
    if (busy) timed_out(name);
    tick();
  endtask

  task automatic wait_rv(input string name);
    int i;
    for (i = 0; i < 400 && !result_valid; i++) tick();
    if (!result_valid) timed_out(name);
  endtask

  task automatic wait_clr(input string name);
    int i;
    for (i = 0; i < 400 && !clf_rst; i++) tick();
    if (!clf_rst) timed_out(name);
  endtask

  initial begin
    clr_mon();
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {clf_rst, clf_start, fft_start, fft_we, result_valid,
                          result_alpha, result_zulu, err_overrun, err_timeout}, 0);

    // Nominal pass: alpha 10 cycles after the last sample.
    clr_mon();
    start_pass();
    feed(NS, 99, 0);
    pulse_alpha_after(10);
    wait_idle("nom_idle");
    chk("nom_clr_count", n_clr, 1);
    chk("nom_cs_count", n_cs, 1);
    chk("nom_fs_count", n_fs, 1);
    chk("nom_cs_after_clr", t_cs - t_clr, 1);
    chk("nom_fs_after_clr", t_fs - t_clr, 2);
    chk("nom_we_count", n_we, 16);
    chk("nom_we_span", t_we_last - t_we_first, 60);
    chk("nom_rv_count", n_rv, 1);
    chk("nom_rv_latency", t_rv - t_we_last, 11);
    chk("nom_alpha", rv_a, 1);
    chk("nom_zulu", rv_z, 0);
    chk("nom_busy_end", t_idle - t_rv, 20);

    // Overrun: three strobes dropped mid-frame.
    clr_mon();
    start_pass();
    feed(NS, 5, 3);
    pulse_alpha_after(10);
    wait_idle("ovr_idle");
    chk("ovr_we_count", n_we, 16);
    chk("ovr_we_span", t_we_last - t_we_first, 72);
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_alpha", rv_a, 1);

    // Timeout: classifier silent.
    clr_mon();
    start_pass();
    feed(NS, 99, 0);
    wait_idle("to_idle");
    chk("to_rv_latency", t_rv - t_we_last, 51);
    chk("to_results", {rv_a, rv_z}, 0);
    chk("to_flag", err_timeout, 1);
    chk("to_overrun_cleared", err_overrun, 0);

    // Zulu on the last timeout cycle, then an arm during HOLD is ignored.
    clr_mon();
    start_pass();
    feed(NS, 99, 0);
    repeat (49) tick();
    clf_zulu = 1; tick(); clf_zulu = 0;
    wait_rv("same_rv");
    repeat (6) tick();
    arm = 1; tick(); arm = 0;
    wait_idle("same_idle");
    chk("same_rv_latency", t_rv - t_we_last, 51);
    chk("same_zulu", rv_z, 1);
    chk("same_alpha", rv_a, 0);
    chk("same_no_timeout", err_timeout, 0);
    chk("hold_arm_ignored", n_clr, 1);
    chk("hold_idle_at", t_idle - t_rv, 20);

    // Auto re-arm, then reset in the middle of the next frame.
    clr_mon();
    auto_rearm = 1;
    start_pass();
    feed(NS, 99, 0);
    pulse_alpha_after(10);
    wait_rv("auto_rv");
    wait_clr("auto_clr");
    auto_rearm = 0;
    repeat (3) tick();
    chk("auto_clr_count", n_clr, 2);
    chk("auto_clr_delay", t_clr - t_rv, 20);
    feed(7, 99, 0);
    rst = 1; tick(); rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {clf_rst, clf_start, fft_start, fft_we, result_valid,
                        result_alpha, result_zulu, err_overrun, err_timeout}, 0);
    clr_mon();
    start_pass();
    feed(NS, 99, 0);
    pulse_alpha_after(10);
    wait_idle("post_rst_idle");
    chk("post_rst_we_count", n_we, 16);
    chk("post_rst_rv_count", n_rv, 1);
    chk("post_rst_alpha", rv_a, 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
